// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath constants and the writeback queue entry type.
package legv8_pkg;

  localparam int WIDTH = 64;
  localparam int AW    = 5;

  // X31 is the zero register: writes to it are architecturally discarded.
  localparam logic [AW-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Producer, register-file write and bypass signals of the writeback queue.
interface writeback_queue_if;
  import legv8_pkg::*;

  logic             MemValid;
  logic [AW-1:0]    MemRd;
  logic [WIDTH-1:0] MemData;
  logic             MemReady;
  logic             AluValid;
  logic [AW-1:0]    AluRd;
  logic [WIDTH-1:0] AluData;
  logic             AluReady;
  logic [AW-1:0]    RW;
  logic [WIDTH-1:0] BusW;
  logic             RegWr;
  logic [AW-1:0]    QA;
  logic             HitA;
  logic [WIDTH-1:0] DataA;
  logic [AW-1:0]    QB;
  logic             HitB;
  logic [WIDTH-1:0] DataB;
  logic             Full;
  logic             Empty;

  modport master (
    output MemValid, MemRd, MemData, AluValid, AluRd, AluData, QA, QB,
    input  MemReady, AluReady, RW, BusW, RegWr, HitA, DataA, HitB, DataB, Full, Empty
  );

  modport slave (
    input  MemValid, MemRd, MemData, AluValid, AluRd, AluData, QA, QB,
    output MemReady, AluReady, RW, BusW, RegWr, HitA, DataA, HitB, DataB, Full, Empty
  );

endinterface

// File: rtl/writeback_queue_bypass.sv
// Newest-first lookup of a register index among the pending queue entries.
module wb_bypass_match
  import legv8_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t                    entries_i [DEPTH],
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [$clog2(DEPTH)-1:0]     head_i,
  input  logic [AW-1:0]                query_i,
  output logic                         hit_o,
  output logic [WIDTH-1:0]             data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk from oldest to newest so the last match (closest to tail) wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if (valid_i[idx] && entries_i[idx].rd == query_i && query_i != ZERO_REG) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback queue merging Mem and ALU results onto the register
// file write port, with two bypass lookup ports for decode.
module writeback_queue
  import legv8_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  writeback_queue_if.slave  wb
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_M1   = (PW+1)'(DEPTH - 1);
  localparam logic [PW:0] CNT_M2   = (PW+1)'(DEPTH - 2);

  wb_entry_t        mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [PW:0]      count_q, count_d;
  logic [DEPTH-1:0] valid;

  logic             mem_acc, alu_acc;
  logic             mem_enq, alu_enq;
  logic             deq;
  logic [1:0]       n_enq;
  logic [PW-1:0]    alu_slot;

  // Readiness looks only at the registered count, so it never depends on Valid.
  assign wb.MemReady = (count_q <= CNT_M1);
  assign wb.AluReady = (count_q <= CNT_M2);

  assign mem_acc = wb.MemValid && wb.MemReady;
  assign alu_acc = wb.AluValid && wb.AluReady;
  assign mem_enq = mem_acc && (wb.MemRd != ZERO_REG);
  assign alu_enq = alu_acc && (wb.AluRd != ZERO_REG);
  assign n_enq   = {1'b0, mem_enq} + {1'b0, alu_enq};
  assign deq     = (count_q != '0);

  // Mem is the older instruction, so it takes the tail slot first.
  assign alu_slot = mem_enq ? tail_q + PW'(1) : tail_q;

  always_comb begin
    head_d  = head_q + PW'(deq);
    tail_d  = tail_q + PW'(n_enq);
    count_d = count_q + (PW+1)'(n_enq) - (PW+1)'(deq);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy is tracked by head/count alone.
  always_ff @(posedge Clk) begin
    if (mem_enq) mem_q[tail_q]   <= '{rd: wb.MemRd, data: wb.MemData};
    if (alu_enq) mem_q[alu_slot] <= '{rd: wb.AluRd, data: wb.AluData};
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    logic [PW-1:0] age;
    assign age       = PW'(gi) - head_q;
    assign valid[gi] = ({1'b0, age} < count_q);
  end

  assign wb.RegWr = deq;
  assign wb.RW    = deq ? mem_q[head_q].rd   : '0;
  assign wb.BusW  = deq ? mem_q[head_q].data : '0;
  assign wb.Empty = (count_q == '0);
  assign wb.Full  = (count_q == CNT_FULL);

  wb_bypass_match #(.DEPTH(DEPTH)) u_bypass_a (
    .entries_i (mem_q),
    .valid_i   (valid),
    .head_i    (head_q),
    .query_i   (wb.QA),
    .hit_o     (wb.HitA),
    .data_o    (wb.DataA)
  );

  wb_bypass_match #(.DEPTH(DEPTH)) u_bypass_b (
    .entries_i (mem_q),
    .valid_i   (valid),
    .head_i    (head_q),
    .query_i   (wb.QB),
    .hit_o     (wb.HitB),
    .data_o    (wb.DataB)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      assert (count_q <= CNT_FULL);
      assert (int'(count_q) + int'(n_enq) - int'(deq) >= 0);
      assert (int'(count_q) + int'(n_enq) - int'(deq) <= DEPTH);
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed vector bench for writeback_queue (DEPTH=4).
module tb_writeback_queue;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  writeback_queue_if bus ();

  writeback_queue #(.DEPTH(4)) dut (
    .Clk   (clk),
    .Reset (rst),
    .wb    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        mv;
    logic [4:0]  mrd;
    logic [63:0] mdat;
    logic        av;
    logic [4:0]  ard;
    logic [63:0] adat;
    logic [4:0]  qa;
    logic [4:0]  qb;
    logic        e_wr;
    logic [4:0]  e_rw;
    logic [63:0] e_busw;
    logic        e_ha;
    logic [63:0] e_da;
    logic        e_hb;
    logic [63:0] e_db;
    logic        e_mr;
    logic        e_ar;
    logic        e_empty;
    logic        e_full;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic mv, input logic [4:0] mrd, input logic [63:0] mdat,
                       input logic av, input logic [4:0] ard, input logic [63:0] adat,
                       input logic [4:0] qa, input logic [4:0] qb);
    bus.MemValid = mv;
    bus.MemRd    = mrd;
    bus.MemData  = mdat;
    bus.AluValid = av;
    bus.AluRd    = ard;
    bus.AluData  = adat;
    bus.QA       = qa;
    bus.QB       = qb;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 5'd5, 5'd5);

    // mv mrd mdat | av ard adat | qa qb || wr rw busw | ha da | hb db | mr ar empty full
    vecs.push_back('{0, 0, 0,     1, 3, 64'hAA,  3, 5,   1, 3, 64'hAA,  1, 64'hAA,  0, 0,      1, 1, 0, 0});
    vecs.push_back('{0, 0, 0,     0, 0, 0,      3, 5,   0, 0, 0,       0, 0,      0, 0,      1, 1, 1, 0});
    vecs.push_back('{1, 4, 64'h11, 1, 4, 64'h22, 4, 3,   1, 4, 64'h11,  1, 64'h22,  0, 0,      1, 1, 0, 0});
    vecs.push_back('{0, 0, 0,     0, 0, 0,      4, 3,   1, 4, 64'h22,  1, 64'h22,  0, 0,      1, 1, 0, 0});
    vecs.push_back('{0, 0, 0,     0, 0, 0,      4, 3,   0, 0, 0,       0, 0,      0, 0,      1, 1, 1, 0});
    vecs.push_back('{0, 0, 0,     1, 31, 64'hFF, 31, 31, 0, 0, 0,      0, 0,      0, 0,      1, 1, 1, 0});
    vecs.push_back('{1, 7, 64'h77, 1, 31, 64'hFF, 7, 31, 1, 7, 64'h77,  1, 64'h77,  0, 0,      1, 1, 0, 0});
    vecs.push_back('{0, 0, 0,     0, 0, 0,      7, 31,  0, 0, 0,       0, 0,      0, 0,      1, 1, 1, 0});
    // back-to-back dual enqueues across pointer wrap
    vecs.push_back('{1, 1, 64'h101, 1, 2, 64'h102, 1, 2, 1, 1, 64'h101, 1, 64'h101, 1, 64'h102, 1, 1, 0, 0});
    vecs.push_back('{1, 3, 64'h103, 1, 4, 64'h104, 1, 4, 1, 2, 64'h102, 0, 0,       1, 64'h104, 1, 0, 0, 0});
    vecs.push_back('{1, 5, 64'h105, 1, 6, 64'h106, 3, 6, 1, 3, 64'h103, 1, 64'h103, 0, 0,       1, 0, 0, 0});
    vecs.push_back('{0, 0, 0,       1, 6, 64'h106, 5, 6, 1, 4, 64'h104, 1, 64'h105, 0, 0,       1, 1, 0, 0});
    vecs.push_back('{0, 0, 0,       1, 6, 64'h106, 5, 6, 1, 5, 64'h105, 1, 64'h105, 1, 64'h106, 1, 1, 0, 0});
    vecs.push_back('{0, 0, 0,       0, 0, 0,       5, 6, 1, 6, 64'h106, 0, 0,       1, 64'h106, 1, 1, 0, 0});
    vecs.push_back('{0, 0, 0,       0, 0, 0,       5, 6, 0, 0, 0,       0, 0,       0, 0,       1, 1, 1, 0});
    // several pending writes to one register: bypass must return the newest
    vecs.push_back('{1, 9, 64'h901, 1, 9, 64'h902, 9, 8, 1, 9, 64'h901, 1, 64'h902, 0, 0,       1, 1, 0, 0});
    vecs.push_back('{1, 9, 64'h903, 0, 0, 0,       9, 8, 1, 9, 64'h902, 1, 64'h903, 0, 0,       1, 1, 0, 0});
    vecs.push_back('{0, 0, 0,       0, 0, 0,       9, 8, 1, 9, 64'h903, 1, 64'h903, 0, 0,       1, 1, 0, 0});
    vecs.push_back('{0, 0, 0,       0, 0, 0,       9, 8, 0, 0, 0,       0, 0,       0, 0,       1, 1, 1, 0});

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.RegWr", 64'(bus.RegWr), 64'd0);
    chk("rst.RW", 64'(bus.RW), 64'd0);
    chk("rst.BusW", bus.BusW, 64'd0);
    chk("rst.Empty", 64'(bus.Empty), 64'd1);
    chk("rst.Full", 64'(bus.Full), 64'd0);
    chk("rst.MemReady", 64'(bus.MemReady), 64'd1);
    chk("rst.AluReady", 64'(bus.AluReady), 64'd1);
    chk("rst.HitA", 64'(bus.HitA), 64'd0);
    $display("reset: RegWr=%0b Empty=%0b HitA=%0b", bus.RegWr, bus.Empty, bus.HitA);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle.RegWr", 64'(bus.RegWr), 64'd0);
    chk("idle.HitA", 64'(bus.HitA), 64'd0);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].mv, vecs[i].mrd, vecs[i].mdat, vecs[i].av, vecs[i].ard,
            vecs[i].adat, vecs[i].qa, vecs[i].qb);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.RegWr", i), 64'(bus.RegWr), 64'(vecs[i].e_wr));
      chk($sformatf("v%0d.RW", i), 64'(bus.RW), 64'(vecs[i].e_rw));
      chk($sformatf("v%0d.BusW", i), bus.BusW, vecs[i].e_busw);
      chk($sformatf("v%0d.HitA", i), 64'(bus.HitA), 64'(vecs[i].e_ha));
      chk($sformatf("v%0d.DataA", i), bus.DataA, vecs[i].e_da);
      chk($sformatf("v%0d.HitB", i), 64'(bus.HitB), 64'(vecs[i].e_hb));
      chk($sformatf("v%0d.DataB", i), bus.DataB, vecs[i].e_db);
      chk($sformatf("v%0d.MemReady", i), 64'(bus.MemReady), 64'(vecs[i].e_mr));
      chk($sformatf("v%0d.AluReady", i), 64'(bus.AluReady), 64'(vecs[i].e_ar));
      chk($sformatf("v%0d.Empty", i), 64'(bus.Empty), 64'(vecs[i].e_empty));
      chk($sformatf("v%0d.Full", i), 64'(bus.Full), 64'(vecs[i].e_full));
      $display("vec %0d: RegWr=%0b RW=%0d BusW=%0h HitA=%0b DataA=%0h HitB=%0b DataB=%0h",
               i, bus.RegWr, bus.RW, bus.BusW, bus.HitA, bus.DataA, bus.HitB, bus.DataB);
      @(negedge clk);
    end

    // reset with three entries pending, while a producer is still offering data
    drive(1, 10, 64'hA1, 1, 11, 64'hA2, 12, 13);
    @(posedge clk);
    @(negedge clk);
    drive(1, 12, 64'hA3, 1, 13, 64'hA4, 12, 13);
    @(posedge clk);
    #1;
    chk("pre.RW", 64'(bus.RW), 64'd11);
    chk("pre.HitA", 64'(bus.HitA), 64'd1);
    chk("pre.AluReady", 64'(bus.AluReady), 64'd0);
    $display("pre-reset: RegWr=%0b RW=%0d BusW=%0h", bus.RegWr, bus.RW, bus.BusW);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 14, 64'hA5, 0, 0, 0, 12, 14);
    @(posedge clk);
    #1;
    chk("mid.RegWr", 64'(bus.RegWr), 64'd0);
    chk("mid.Empty", 64'(bus.Empty), 64'd1);
    chk("mid.RW", 64'(bus.RW), 64'd0);
    chk("mid.BusW", bus.BusW, 64'd0);
    chk("mid.HitA", 64'(bus.HitA), 64'd0);
    chk("mid.HitB", 64'(bus.HitB), 64'd0);
    $display("mid-reset: RegWr=%0b Empty=%0b", bus.RegWr, bus.Empty);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 12, 13);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post%0d.RegWr", c), 64'(bus.RegWr), 64'd0);
      chk($sformatf("post%0d.Empty", c), 64'(bus.Empty), 64'd1);
      chk($sformatf("post%0d.HitA", c), 64'(bus.HitA), 64'd0);
      $display("post-reset %0d: RegWr=%0b RW=%0d", c, bus.RegWr, bus.RW);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
